// File: rtl/rgb_dac_pkg.sv
// Shared types and constants for the RGB888 to 3-channel laser-diode DAC serial link.
package rgb_dac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    LDAC  = 2'd3
  } state_e;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  localparam int WORD_BITS = 16;

  function automatic logic [WORD_BITS-1:0] dac_word(
    input logic [3:0] cmd,
    input logic [3:0] addr,
    input logic [7:0] level
  );
    return {cmd, addr, level};
  endfunction

endpackage

// File: rtl/dac_word_shifter.sv
// Serialises one DAC word MSB first: SCLK idles high, SDI changes on the rising
// edge, the DAC samples on the falling edge. word_done flags the final cycle.
module dac_word_shifter
  import rgb_dac_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WORD_BITS-1:0] word,
  output logic                 sclk,
  output logic                 sdi,
  output logic                 word_done
);

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [4:0]  HALF_LAST = 5'(2 * WORD_BITS - 1);

  logic                 active;
  logic [15:0]          div_cnt;
  logic [4:0]           half_cnt;
  logic [WORD_BITS-1:0] shreg;
  logic                 half_end;
  logic                 rise;

  assign half_end  = active && (div_cnt == DIV_LAST);
  assign word_done = half_end && (half_cnt == HALF_LAST);
  // Odd half-periods are the low phase; leaving one means SCLK rises and the next bit goes out.
  assign rise      = half_end && (half_cnt != HALF_LAST) && half_cnt[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active   <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= '0;
      sclk     <= 1'b1;
      sdi      <= 1'b0;
    end else if (load) begin
      active   <= 1'b1;
      div_cnt  <= '0;
      half_cnt <= '0;
      sclk     <= 1'b1;
      sdi      <= word[WORD_BITS-1];
    end else if (word_done) begin
      active   <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= '0;
      sclk     <= 1'b1;
      sdi      <= 1'b0;
    end else if (half_end) begin
      div_cnt  <= '0;
      half_cnt <= half_cnt + 5'd1;
      sclk     <= half_cnt[0];
      if (half_cnt[0]) begin
        sdi <= shreg[WORD_BITS-1];
      end
    end else if (active) begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= {word[WORD_BITS-2:0], 1'b0};
    end else if (rise) begin
      shreg <= {shreg[WORD_BITS-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/rgb_dac_spi.sv
// Accepts one RGB888 sample, sends R/G/B words to the laser DAC, then pulses LDAC
// so all three channels update together. laser_en=0 at acceptance blanks the frame.
module rgb_dac_spi
  import rgb_dac_pkg::*;
#(
  parameter int       CLK_DIV = 4,
  parameter logic [3:0] DAC_CMD = 4'h3,
  parameter logic [3:0] ADDR_R  = 4'h0,
  parameter logic [3:0] ADDR_G  = 4'h1,
  parameter logic [3:0] ADDR_B  = 4'h2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] rgb888,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        laser_en,
  output logic        dac_sclk,
  output logic        dac_sdi,
  output logic        dac_sync_n,
  output logic        dac_ldac_n,
  output logic        frame_done
);

  localparam logic [15:0] GAP_LAST = 16'(2 * CLK_DIV - 1);

  state_e               state;
  state_e               state_nx;
  logic [1:0]           ch;
  logic [1:0]           ch_nx;
  logic [1:0]           ch_inc;
  logic [15:0]          cnt;
  logic [15:0]          cnt_nx;
  logic                 in_ready_nx;
  logic                 sync_n_nx;
  logic                 ldac_n_nx;
  logic                 frame_done_nx;
  logic [23:0]          sample;
  logic [23:0]          sample_src;
  logic                 accept;
  logic                 load;
  logic [WORD_BITS-1:0] load_word;
  logic                 word_done;

  function automatic logic [WORD_BITS-1:0] chan_word(
    input logic [1:0]  c,
    input logic [23:0] s
  );
    case (c)
      CH_R:    return dac_word(DAC_CMD, ADDR_R, s[23:16]);
      CH_G:    return dac_word(DAC_CMD, ADDR_G, s[15:8]);
      default: return dac_word(DAC_CMD, ADDR_B, s[7:0]);
    endcase
  endfunction

  assign accept     = in_valid & in_ready;
  assign sample_src = laser_en ? rgb888 : 24'h0;
  assign ch_inc     = ch + 2'd1;

  always_comb begin
    state_nx      = state;
    ch_nx         = ch;
    cnt_nx        = cnt;
    in_ready_nx   = in_ready;
    sync_n_nx     = dac_sync_n;
    ldac_n_nx     = dac_ldac_n;
    frame_done_nx = 1'b0;
    load          = 1'b0;
    load_word     = chan_word(CH_R, sample_src);
    case (state)
      IDLE: begin
        if (accept) begin
          // The first word comes straight from the input so SYNC can fall on the accepting edge.
          state_nx    = SHIFT;
          ch_nx       = CH_R;
          in_ready_nx = 1'b0;
          sync_n_nx   = 1'b0;
          load        = 1'b1;
          load_word   = chan_word(CH_R, sample_src);
        end
      end
      SHIFT: begin
        if (word_done) begin
          state_nx  = GAP;
          sync_n_nx = 1'b1;
          cnt_nx    = '0;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx = '0;
          if (ch == CH_B) begin
            state_nx  = LDAC;
            ldac_n_nx = 1'b0;
          end else begin
            state_nx  = SHIFT;
            ch_nx     = ch_inc;
            sync_n_nx = 1'b0;
            load      = 1'b1;
            load_word = chan_word(ch_inc, sample);
          end
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      LDAC: begin
        if (cnt == GAP_LAST) begin
          cnt_nx        = '0;
          state_nx      = IDLE;
          ldac_n_nx     = 1'b1;
          frame_done_nx = 1'b1;
          in_ready_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ch         <= CH_R;
      cnt        <= '0;
      in_ready   <= 1'b1;
      dac_sync_n <= 1'b1;
      dac_ldac_n <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      ch         <= ch_nx;
      cnt        <= cnt_nx;
      in_ready   <= in_ready_nx;
      dac_sync_n <= sync_n_nx;
      dac_ldac_n <= ldac_n_nx;
      frame_done <= frame_done_nx;
    end
  end

  // Blanking is resolved here, so laser_en only matters on the accepting edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      sample <= sample_src;
    end
  end

  dac_word_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .word      (load_word),
    .sclk      (dac_sclk),
    .sdi       (dac_sdi),
    .word_done (word_done)
  );

endmodule

// File: tb/tb_rgb_dac_spi.sv
// Directed bench for rgb_dac_spi: a CLK_DIV=4 and a CLK_DIV=1 instance, each watched by an SPI monitor.
module tb_rgb_dac_spi;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] rgb888 = 24'h0;
  logic        laser_en = 1'b1;
  logic [1:0]  in_valid = 2'b00;
  logic [1:0]  in_ready, sclk, sdi, sync_n, ldac_n, fdone;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  rgb_dac_spi #(.CLK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .rgb888(rgb888), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .laser_en(laser_en), .dac_sclk(sclk[0]),
    .dac_sdi(sdi[0]), .dac_sync_n(sync_n[0]), .dac_ldac_n(ldac_n[0]),
    .frame_done(fdone[0])
  );

  rgb_dac_spi #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .rgb888(rgb888), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .laser_en(laser_en), .dac_sclk(sclk[1]),
    .dac_sdi(sdi[1]), .dac_sync_n(sync_n[1]), .dac_ldac_n(ldac_n[1]),
    .frame_done(fdone[1])
  );

  // Monitor state, one slot per instance; sampled on the falling clk edge.
  logic [15:0] w4[$];
  logic [15:0] w1[$];
  logic [15:0] sh [2] = '{16'h0, 16'h0};
  int nbits [2]     = '{0, 0};
  int busy_run [2]  = '{0, 0};
  int last_busy [2] = '{0, 0};
  int ldac_run [2]  = '{0, 0};
  int last_ldac [2] = '{0, 0};
  int ldac_pulses [2] = '{0, 0};
  int fd_cnt [2]    = '{0, 0};
  int sdi_bad [2]   = '{0, 0};
  int last_fall [2] = '{0, 0};
  int period [2]    = '{0, 0};
  int cyc = 0;
  logic [1:0] prev_sclk = 2'b11;
  logic [1:0] prev_ready = 2'b11;
  logic [1:0] prev_ldac = 2'b11;

  task automatic mon(input int i);
    if (sync_n[i] === 1'b1) begin
      nbits[i] = 0;
      if (sdi[i] !== 1'b0) sdi_bad[i]++;
    end else if (prev_sclk[i] === 1'b1 && sclk[i] === 1'b0) begin
      sh[i] = {sh[i][14:0], sdi[i]};
      if (nbits[i] > 0) period[i] = cyc - last_fall[i];
      last_fall[i] = cyc;
      nbits[i]++;
      if (nbits[i] == 16) begin
        if (i == 0) w4.push_back(sh[i]);
        else w1.push_back(sh[i]);
        nbits[i] = 0;
      end
    end
    if (in_ready[i] === 1'b0) busy_run[i]++;
    else if (prev_ready[i] === 1'b0) begin
      last_busy[i] = busy_run[i];
      busy_run[i] = 0;
    end
    if (ldac_n[i] === 1'b0) ldac_run[i]++;
    else if (prev_ldac[i] === 1'b0) begin
      last_ldac[i] = ldac_run[i];
      ldac_run[i] = 0;
      ldac_pulses[i]++;
    end
    if (fdone[i] === 1'b1) fd_cnt[i]++;
    prev_sclk[i]  = sclk[i];
    prev_ready[i] = in_ready[i];
    prev_ldac[i]  = ldac_n[i];
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) mon(i);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [23:0] d, input logic le, input string tag);
    tick();
    rgb888 = d;
    laser_en = le;
    in_valid[i] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
    check({tag, "_accept"}, {in_ready[i], sync_n[i], sclk[i]}, 3'b001);
  endtask

  task automatic wait_ready(input int i, input int budget, input string tag);
    int k = 0;
    do begin
      tick();
      k++;
    end while (in_ready[i] !== 1'b1 && k < budget);
    check({tag, "_ready_back"}, in_ready[i], 1'b1);
  endtask

  task automatic check_pop(input int i, input string tag, input logic [15:0] exp);
    logic [15:0] v = 16'hDEAD;
    if (i == 0 && w4.size() > 0) v = w4.pop_front();
    if (i == 1 && w1.size() > 0) v = w1.pop_front();
    check(tag, v, exp);
  endtask

  int pulses_before, fd_before;

  initial begin
    // Asynchronous reset while clk is low, well before the first rising edge.
    #2 reset = 1'b1;
    #1;
    check("reset_async_outs", {in_ready[0], sclk[0], sdi[0], sync_n[0], ldac_n[0], fdone[0]}, 6'b110110);
    check("reset_async_dut1", {in_ready[1], sclk[1], sync_n[1], ldac_n[1]}, 4'b1111);
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("idle_after_reset", {in_ready[0], sync_n[0], ldac_n[0], fdone[0]}, 4'b1110);

    // Normal frame, CLK_DIV=4.
    send(0, 24'hFF8001, 1'b1, "t2");
    wait_ready(0, 2000, "t2");
    check("t2_nwords", w4.size(), 3);
    check_pop(0, "t2_word_r", 16'h30FF);
    check_pop(0, "t2_word_g", 16'h3180);
    check_pop(0, "t2_word_b", 16'h3201);
    check("t2_busy_cycles", last_busy[0], 416);
    check("t2_ldac_cycles", last_ldac[0], 8);
    check("t2_frame_done", fd_cnt[0], 1);
    check("t2_sclk_period", period[0], 8);

    // Blanked frame.
    send(0, 24'hFFFFFF, 1'b0, "t3");
    wait_ready(0, 2000, "t3");
    check("t3_nwords", w4.size(), 3);
    check_pop(0, "t3_word_r", 16'h3000);
    check_pop(0, "t3_word_g", 16'h3100);
    check_pop(0, "t3_word_b", 16'h3200);
    check("t3_frame_done", fd_cnt[0], 2);

    // Back-to-back with in_valid held high; data changes while busy.
    tick();
    rgb888 = 24'h123456;
    laser_en = 1'b1;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    check("t4_first_accept", in_ready[0], 1'b0);
    rgb888 = 24'hABCDEF;
    wait_ready(0, 2000, "t4a");
    check("t4_busy_first", last_busy[0], 416);
    @(posedge clk);
    #1;
    check("t4_second_accept", in_ready[0], 1'b0);
    in_valid[0] = 1'b0;
    repeat (50) tick();
    rgb888 = 24'h777777;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (100) tick();
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    wait_ready(0, 2000, "t4b");
    check("t4_nwords", w4.size(), 6);
    check_pop(0, "t4_f1_r", 16'h3012);
    check_pop(0, "t4_f1_g", 16'h3134);
    check_pop(0, "t4_f1_b", 16'h3256);
    check_pop(0, "t4_f2_r", 16'h30AB);
    check_pop(0, "t4_f2_g", 16'h31CD);
    check_pop(0, "t4_f2_b", 16'h32EF);
    repeat (20) tick();
    check("t4_frame_done", fd_cnt[0], 4);
    check("t4_still_idle", in_ready[0], 1'b1);

    // Reset in the middle of the green word.
    send(0, 24'hAA5533, 1'b1, "t5");
    repeat (180) tick();
    check("t5_mid_g_sync", sync_n[0], 1'b0);
    check("t5_nwords_before", w4.size(), 1);
    check_pop(0, "t5_word_r", 16'h30AA);
    pulses_before = ldac_pulses[0];
    fd_before = fd_cnt[0];
    #1 reset = 1'b1;
    #1;
    check("t5_reset_outs", {in_ready[0], sclk[0], sdi[0], sync_n[0], ldac_n[0], fdone[0]}, 6'b110110);
    repeat (2) tick();
    reset = 1'b0;
    repeat (500) tick();
    check("t5_no_ldac", ldac_pulses[0] - pulses_before, 0);
    check("t5_no_frame_done", fd_cnt[0] - fd_before, 0);
    check("t5_no_partial_word", w4.size(), 0);
    send(0, 24'h010203, 1'b1, "t5b");
    wait_ready(0, 2000, "t5b");
    check("t5b_nwords", w4.size(), 3);
    check_pop(0, "t5b_word_r", 16'h3001);
    check_pop(0, "t5b_word_g", 16'h3102);
    check_pop(0, "t5b_word_b", 16'h3203);

    // CLK_DIV=1 instance.
    fd_before = fd_cnt[1];
    send(1, 24'h5AC3F0, 1'b1, "t6");
    wait_ready(1, 500, "t6");
    check("t6_nwords", w1.size(), 3);
    check_pop(1, "t6_word_r", 16'h305A);
    check_pop(1, "t6_word_g", 16'h31C3);
    check_pop(1, "t6_word_b", 16'h32F0);
    check("t6_busy_cycles", last_busy[1], 104);
    check("t6_ldac_cycles", last_ldac[1], 2);
    check("t6_sclk_period", period[1], 2);
    check("t6_frame_done", fd_cnt[1] - fd_before, 1);

    check("sdi_idle_low_div4", sdi_bad[0], 0);
    check("sdi_idle_low_div1", sdi_bad[1], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rgb_dac_spi.md
Name: rgb_dac_spi

Overview:
- Downstream consumer of the RGB565-to-RGB888 upconverter in the laser projector colour path.
- Accepts one 24-bit RGB888 sample per handshake and serialises it as three 16-bit words (R, G, B) to a 3-channel serial laser-diode DAC.
- After all three words are shifted, pulses LDAC so the red, green and blue intensities update on the same edge.
- A laser-enable input forces all-zero intensities as the safety blanking path.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range ≥1.
- DAC_CMD, 4'h3: command nibble placed in bits [15:12] of every DAC word.
- ADDR_R, 4'h0: DAC channel address for red.
- ADDR_G, 4'h1: DAC channel address for green.
- ADDR_B, 4'h2: DAC channel address for blue.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rgb888  in  24  {R[23:16], G[15:8], B[7:0]} sample from upconverter
- in_valid  in  1  rgb888 valid
- in_ready  out  1  block idle; sample accepted on in_valid & in_ready
- laser_en  in  1  0 = send zero intensity on all channels
- dac_sclk  out  1  serial clock; idles high
- dac_sdi  out  1  serial data, MSB first
- dac_sync_n  out  1  frame select, active low
- dac_ldac_n  out  1  load strobe, active low
- frame_done  out  1  one-cycle pulse when ldac_n returns high

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values (asserted immediately, asynchronously):
  - in_ready=1, dac_sclk=1, dac_sdi=0, dac_sync_n=1, dac_ldac_n=1, frame_done=0.
  - FSM=IDLE; all counters cleared.
- All outputs are registered; no combinational paths from input to output.
- Acceptance: on the clk edge where in_valid & in_ready, latch rgb888, or 24'h0 if laser_en=0 at that edge.
  - in_ready drops on that same edge.
  - laser_en is sampled only at acceptance.
- in_valid while in_ready=0 is ignored; no queueing.
- Word format: {DAC_CMD[3:0], ADDR[3:0], colour[7:0]}, sent in order R, G, B.
- FSM states: IDLE -> SHIFT -> GAP -> (SHIFT for next channel | LDAC after B) -> IDLE.
- SHIFT, per bit (MSB first):
  - dac_sdi updates with dac_sclk rising to high; the DAC samples on the falling edge.
  - dac_sclk is high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - dac_sync_n is low for exactly 32*CLK_DIV cycles, starting the cycle after acceptance (or after GAP).
- GAP: dac_sync_n=1, dac_sclk=1 for 2*CLK_DIV cycles.
- LDAC: dac_ldac_n=0 for 2*CLK_DIV cycles. On the edge it returns high:
  - frame_done pulses for 1 cycle;
  - in_ready=1;
  - FSM returns to IDLE.
- Total latency: in_ready is low for exactly 104*CLK_DIV cycles after the accepting edge (416 for CLK_DIV=4).
- A new in_valid on the first in_ready=1 cycle is accepted; back-to-back frames have no extra idle.
- Counters:
  - div counter 0..CLK_DIV-1;
  - half-bit counter 0..31;
  - channel counter 0..2, which selects the address and colour byte.
- Reset mid-transaction: the frame is discarded, outputs return to reset values, and no LDAC pulse is produced. The DAC sees sync_n rise without 16 bits, which aborts the write.
- dac_sdi=0 whenever dac_sync_n=1.

Decomposition:
- Package rgb_dac_pkg:
  - FSM state encoding (IDLE, SHIFT, GAP, LDAC);
  - channel index constants CH_R=0, CH_G=1, CH_B=2;
  - WORD_BITS=16.
- One sub-module, dac_word_shifter:
  - loads a 16-bit word and owns the div counter, sclk and sdi generation;
  - outputs word_done;
  - the top level owns the handshake, channel sequencing, GAP/LDAC and blanking.

Test Plan:
- Reset → all outputs at reset values, in_ready=1; assert reset asynchronously between clk edges and check the outputs change immediately.
- CLK_DIV=4, laser_en=1, rgb888=24'hFF8001 → SPI monitor captures 16'h30FF, 16'h3180, 16'h3201; ldac_n low 8 cycles after the third word's GAP; frame_done once; in_ready low exactly 416 cycles.
- laser_en=0, rgb888=24'hFFFFFF → words 16'h3000, 16'h3100, 16'h3200.
- Back-to-back in_valid held high with 24'h123456 then 24'hABCDEF:
  - both frames are sent in order with no dropped or duplicated frame;
  - the second accept occurs on the first in_ready=1 cycle;
  - in_valid pulses during busy are ignored.
- Reset asserted mid-G-word → sync_n=1 immediately, ldac_n never pulses, frame_done=0; the next frame 24'h010203 is sent correctly.
- CLK_DIV=1 → SCLK period 2 cycles, total busy 104 cycles, words correct.
